dmem_port_arbiter: RTL and testbench

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

---
 rtl/dmem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port data-memory arbiter: MEM stage (port 0) and loader/DMA (port 1) share one
// synchronous-read memory. Port 0 has priority, with starvation relief and locked bursts for port 1.
module dmem_port_arbiter #(
    parameter int unsigned DBITS        = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_BURST    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [DBITS-1:0] p0_addr,
    input  logic [DBITS-1:0] p0_wdata,
    output logic             p0_gnt,
    output logic             p0_rvalid,
    output logic             stall_MEM,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [DBITS-1:0] p1_addr,
    input  logic [DBITS-1:0] p1_wdata,
    input  logic             p1_lock,
    output logic             p1_gnt,
    output logic             p1_rvalid,
    output logic [DBITS-1:0] rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    input  logic [DBITS-1:0] mem_rdata
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef struct packed {
        logic             we;
        logic [DBITS-1:0] addr;
        logic [DBITS-1:0] wdata;
    } mem_req_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;
    logic [1:0]    rd_owner;
    logic          gnt0;
    logic          gnt1;
    logic          lock_hold;
    logic          starved;
    mem_req_t      req0;
    mem_req_t      req1;
    mem_req_t      req_sel;

    // Port 1 keeps ownership while its lock is held and the burst budget remains.
    assign lock_hold = (state == OWN1) && p1_lock && p1_req && (burst_cnt < BW'(MAX_BURST));
    assign starved   = (starve_cnt == SW'(STARVE_LIMIT));

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            burst_cnt  <= burst_nxt;
        end
    end

    // Grant decision, next owner and counter updates.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_nxt  = IDLE;
        starve_nxt = '0;
        burst_nxt  = '0;

        if (reset) begin
            if (lock_hold) begin
                gnt1 = 1'b1;
            end else if (p0_req && p1_req) begin
                gnt1 = starved;
                gnt0 = !starved;
            end else begin
                gnt0 = p0_req;
                gnt1 = p1_req;
            end
        end

        if (gnt0) begin
            state_nxt = OWN0;
        end else if (gnt1) begin
            state_nxt = OWN1;
        end

        if (p1_req && !gnt1) begin
            starve_nxt = starved ? starve_cnt : starve_cnt + SW'(1);
        end

        // A grant at the budget limit is ordinary arbitration and restarts the burst count.
        if (gnt1 && p1_lock && (burst_cnt < BW'(MAX_BURST))) begin
            burst_nxt = burst_cnt + BW'(1);
        end
    end

    // Memory request mux driven by the granted port.
    assign req0 = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
    assign req1 = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};
    assign req_sel = gnt1 ? req1 : req0;

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign stall_MEM = reset & p0_req & ~gnt0;
    assign mem_en    = gnt0 | gnt1;
    assign mem_we    = mem_en & req_sel.we;
    assign mem_addr  = req_sel.addr;
    assign mem_wdata = req_sel.wdata;

    // One-hot owner of the read in flight; read data returns the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_owner <= 2'b00;
        end else begin
            rd_owner <= {gnt1 & ~p1_we, gnt0 & ~p0_we};
        end
    end

    assign p0_rvalid = rd_owner[0];
    assign p1_rvalid = rd_owner[1];
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed scenarios plus constrained-random
// traffic, checked against a queue-based reference model and a behavioural memory.
module tb_dmem_port_arbiter;
    localparam int DBITS        = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int MAX_BURST    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             p0_req, p0_we, p0_gnt, p0_rvalid, stall_MEM;
    logic [DBITS-1:0] p0_addr, p0_wdata;
    logic             p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [DBITS-1:0] p1_addr, p1_wdata;
    logic [DBITS-1:0] rdata;
    logic             mem_en, mem_we;
    logic [DBITS-1:0] mem_addr, mem_wdata;
    logic [DBITS-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .DBITS(DBITS), .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .stall_MEM(stall_MEM),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          g0;
        bit          g1;
        bit          stall;
        bit          en;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        bit          owner;
        logic [31:0] data;
        int          due;
    } rd_t;

    exp_t gnt_q[$];
    rd_t  rd_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [31:0] tb_mem  [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    // Reference-model memory of who owned the last grant, p1 denial streak, locked run length.
    int last_owner = 0;
    int denied = 0;
    int run = 0;
    bit last_g0 = 0;
    bit last_g1 = 0;

    function automatic logic [31:0] fill(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Behavioural synchronous-read memory answering the DUT's memory bus.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] = mem_wdata;
            else mem_rdata <= tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : fill(mem_addr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference model: apply the arbitration rules to this cycle's inputs and queue expectations.
    task automatic model();
        exp_t e;
        rd_t  r;
        bit   g0;
        bit   g1;
        g0 = 0;
        g1 = 0;
        if (!reset) begin
            last_owner = 0;
            denied = 0;
            run = 0;
            while (rd_q.size() > 0 && rd_q[rd_q.size()-1].due >= cyc) void'(rd_q.pop_back());
        end else begin
            if (last_owner == 2 && p1_lock && p1_req && run < MAX_BURST) g1 = 1;
            else if (p0_req && p1_req) begin
                if (denied == STARVE_LIMIT) g1 = 1;
                else g0 = 1;
            end
            else if (p0_req) g0 = 1;
            else if (p1_req) g1 = 1;
            denied = (p1_req && !g1) ? ((denied < STARVE_LIMIT) ? denied + 1 : denied) : 0;
            run = (g1 && p1_lock && run < MAX_BURST) ? run + 1 : 0;
            last_owner = g0 ? 1 : (g1 ? 2 : 0);
        end
        last_g0 = g0;
        last_g1 = g1;
        e.g0 = g0;
        e.g1 = g1;
        e.stall = reset && p0_req && !g0;
        e.en = g0 || g1;
        e.we = g0 ? p0_we : p1_we;
        e.addr = g0 ? p0_addr : p1_addr;
        e.wdata = g0 ? p0_wdata : p1_wdata;
        gnt_q.push_back(e);
        if (e.en) begin
            if (e.we) ref_mem[e.addr] = e.wdata;
            else begin
                r.owner = g1;
                r.data = ref_mem.exists(e.addr) ? ref_mem[e.addr] : fill(e.addr);
                r.due = cyc + 1;
                rd_q.push_back(r);
            end
        end
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                         input bit l1);
        tick();
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_lock = l1;
        model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    // Monitor: compares grants every cycle and read returns whenever the DUT flags one.
    initial begin
        exp_t e;
        rd_t  r;
        forever begin
            @(negedge clk);
            if (gnt_q.size() > 0) begin
                e = gnt_q.pop_front();
                check("p0_gnt", 32'(p0_gnt), 32'(e.g0));
                check("p1_gnt", 32'(p1_gnt), 32'(e.g1));
                check("stall_MEM", 32'(stall_MEM), 32'(e.stall));
                check("mem_en", 32'(mem_en), 32'(e.en));
                if (e.en) begin
                    check("mem_we", 32'(mem_we), 32'(e.we));
                    check("mem_addr", mem_addr, e.addr);
                    if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                end
            end
            while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
                r = rd_q.pop_front();
                checks++;
                errors++;
                $display("FAIL rvalid_missing cycle %0d: got rvalid 0 expected 1 for read due %0d", cyc, r.due);
            end
            if (p0_rvalid || p1_rvalid) begin
                if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                    r = rd_q.pop_front();
                    check("p0_rvalid", 32'(p0_rvalid), 32'(!r.owner));
                    check("p1_rvalid", 32'(p1_rvalid), 32'(r.owner));
                    check("rdata", rdata, r.data);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_unexpected cycle %0d: got p0/p1 rvalid %b%b expected 00",
                             cyc, p0_rvalid, p1_rvalid);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lock_mode;
        reset = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_lock = 0;
        tb_mem[32'h40] = 32'hDEAD_BEEF;
        ref_mem[32'h40] = 32'hDEAD_BEEF;

        // Reset held with requests present: no grants, no strobes.
        idle(2);
        drive(1, 0, 32'h10, '0, 1, 0, 32'h20, '0, 0);
        tick();
        reset = 1'b1;
        p0_req = 0; p1_req = 0;
        model();

        // Idle cycles.
        idle(10);

        // Single p0 read returning preloaded data.
        drive(1, 0, 32'h40, '0, 0, 0, '0, '0, 0);
        idle(2);

        // Both ports reading continuously: starvation relief every fifth cycle.
        for (int i = 0; i < 15; i++) drive(1, 0, 32'h100, '0, 1, 0, 32'h200, '0, 0);
        idle(2);

        // Locked p1 burst with p0 joining one cycle later.
        drive(0, 0, '0, '0, 1, 0, 32'h300, '0, 1);
        for (int i = 0; i < 11; i++) drive(1, 0, 32'h104, '0, 1, 0, 32'h300, '0, 1);
        idle(2);

        // p1 write then p0 read of the same address.
        drive(0, 0, '0, '0, 1, 1, 32'h80, 32'h1234_5678, 0);
        drive(1, 0, 32'h80, '0, 0, 0, '0, '0, 0);
        idle(2);

        // Reset arriving while a p1 read is in flight.
        drive(0, 0, '0, '0, 1, 0, 32'h200, '0, 0);
        tick();
        reset = 1'b0;
        p1_req = 0;
        model();
        tick();
        reset = 1'b1;
        p0_req = 1; p0_we = 0; p0_addr = 32'h44;
        model();
        idle(2);

        // Randomized traffic; requests are held stable until granted.
        lock_mode = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            if (!(p0_req && !last_g0)) begin
                p0_req = ($urandom_range(0, 99) < 60);
                p0_we = 1'($urandom_range(0, 1));
                p0_addr = 32'($urandom_range(0, 15)) << 2;
                p0_wdata = $urandom;
            end
            if (!(p1_req && !last_g1)) begin
                if ($urandom_range(0, 19) == 0) lock_mode = !lock_mode;
                p1_req = ($urandom_range(0, 99) < 55);
                p1_we = 1'($urandom_range(0, 1));
                p1_addr = 32'($urandom_range(0, 15)) << 2;
                p1_wdata = $urandom;
                p1_lock = lock_mode;
            end
            model();
        end
        reset = 1'b1;
        idle(3);

        repeat (2) @(negedge clk);
        #1;
        check("gnt_queue_left", 32'(gnt_q.size()), 32'd0);
        check("rd_queue_left", 32'(rd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
